module_display_scan: RTL and testbench
======================================

Name: module_display_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode 7-segment display.
- Holds a hex value and scans one digit at a time. Per digit it presents the nibble on `data` for the existing hex-to-segment decoder and drives the matching active-low anode.
- Sits between user logic (value source) and the decoder/pins.
- Value updates are double-buffered and committed only at frame boundaries, so there is no tearing.

Parameters:
- N_DIGITS, 4, number of digits; range 2..8
- CLK_FREQ_HZ, 27000000, input clock frequency
- REFRESH_HZ, 250, full-frame refresh rate; TICKS = CLK_FREQ_HZ/(REFRESH_HZ*N_DIGITS) clocks per digit; elaboration error if TICKS < 4
- DEAD_CYCLES, 2, clocks with all anodes off after each digit switch; must be < TICKS

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  4*N_DIGITS  hex value; nibble k is digit k; digit 0 is the least significant and rightmost
- load  in  1  one-cycle strobe: capture `value` into the pending buffer
- data  out  4  nibble of the currently scanned digit, to module_7segmentos
- anodos  out  N_DIGITS  active-low one-hot digit enable
- digit_idx  out  $clog2(N_DIGITS)  index of the digit currently scanned
- updated  out  1  one-cycle pulse when pending is committed to the display register

Behaviour:
- Reset (async assert, sync release): all registers are cleared.
  - Prescaler = 0, idx = 0, dead = 0.
  - disp_reg = 0, pend_reg = 0, pend_flag = 0.
  - data = 0, anodos = all 1 (off), digit_idx = 0, updated = 0.
- Prescaler:
  - Counts 0..TICKS-1 and wraps to 0.
  - tick = (count == TICKS-1), a single-cycle pulse.
- Scan index: on tick, idx <= (idx == N_DIGITS-1) ? 0 : idx+1.
- Dead time:
  - On tick, dead <= DEAD_CYCLES; otherwise it decrements while nonzero.
  - While dead != 0 (next-state), anodos <= all 1.
- Outputs are registered and computed from next-state idx/dead on the same edge:
  - data = disp_reg[idx].
  - anodos = ~(1<<idx) when not dead.
  - digit_idx = idx.
  - Together these give a single consistent transition with no glitch between anode and data.
- Load path:
  - load=1 -> pend_reg <= value, pend_flag <= 1 (next edge).
  - Repeated loads before commit overwrite; the last one wins.
- Commit:
  - Occurs on tick with idx == N_DIGITS-1, i.e. a frame wrap.
  - If pend_flag: disp_reg <= pend_reg, pend_flag <= 0, updated <= 1 for one cycle.
  - The new frame's digit 0 already shows the committed value.
- Simultaneous load and commit on the same edge:
  - disp_reg takes pend_reg's prior contents.
  - pend_reg takes the new value and pend_flag stays 1; it commits at the next frame.
  - If pend_flag was 0, disp_reg is unchanged and the new value is pending.
- Latency: load to displayed ≤ 1 frame + 1 clock.
- Reset mid-frame: immediately blanks (anodos all 1) and discards the pending value.
- anodos is never more than one bit low; all-high during reset and dead time.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits above the most significant nonzero nibble of disp_reg are blanked (anode held high for the whole slot; data still driven).
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - The blank mask is recomputed from disp_reg (combinational leading-zero detect).
- Undefined: all digits are always shown and the logic is absent.

Decomposition:
- Package pkg_display:
  - DIGIT_W = 4.
  - Typedef nibble_t (logic [3:0]).
  - Function ticks_per_digit(clk_hz, refresh_hz, n).
  - Anode-off constant ANODOS_OFF polarity.
- Sub-module module_prescaler (TICKS param; outputs tick). Reused elsewhere for debouncers.
- Decoder module_7segmentos is instantiated by the parent, not inside this block.

Test Plan (CLK_FREQ_HZ=1000, REFRESH_HZ=50, N_DIGITS=4, DEAD_CYCLES=1 -> TICKS=5):
- Reset: hold rst_n=0 with clock toggling -> anodos=4'b1111, data=0, updated=0; release, then first tick after 5 clocks.
- Scan: load=1 with value=16'h1A3F, run 2 frames -> updated pulses once at the first frame wrap.
  - Then per slot: anodos 1110/1101/1011/0111 with data F/3/A/1.
  - Exactly 1 blank clock (1111) after each switch; idx wraps 3->0.
- Last-wins: load 16'h1111 then 16'h2222 within one frame -> after wrap all digits show 2; a single updated pulse.
- Simultaneous: pending=16'h1234, load 16'h5678 on the commit edge -> next frame shows 1234, following frame 5678; two updated pulses.
- Reset mid-frame: assert rst_n=0 at idx=2 with a pending load -> anodos=1111 asynchronously; after release disp shows 0000 and the pending value is lost.
- Feature (LEADING_ZERO_BLANK_EN): value=16'h0042 -> digits 2,3 blanked, digits 0,1 show 2 and 4; value=16'h0000 -> only digit 0 lit, showing 0.

Source files
------------

// File: rtl/module_display_scan_pkg.sv
// Shared definitions for the 7-segment display scanner: digit width, nibble
// type, anode polarity and the per-digit tick computation.
package pkg_display;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] nibble_t;

  // Common-anode display: a high anode line means the digit is dark.
  localparam logic ANODOS_OFF = 1'b1;

  // Clocks spent on each digit so that all n digits refresh at refresh_hz.
  function automatic int ticks_per_digit(input int clk_hz, input int refresh_hz, input int n);
    return clk_hz / (refresh_hz * n);
  endfunction

endpackage

// File: rtl/module_display_scan_prescaler.sv
// Free-running divider: emits a one-clock tick every TICKS clocks.
// Also used as the sample strobe source for debouncers.
module module_prescaler #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(TICKS - 1));

  // Count 0..TICKS-1 and wrap on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/module_display_scan.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with double-buffered
// value updates committed at frame wrap.
// Optional macro LEADING_ZERO_BLANK_EN: darkens digits above the most
// significant nonzero nibble (digit 0 always lit).
// Reset release is expected to be synchronised to clk by the parent.
module module_display_scan
  import pkg_display::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int REFRESH_HZ  = 250,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIGIT_W*N_DIGITS-1:0] value,
  input  logic                        load,
  output nibble_t                     data,
  output logic [N_DIGITS-1:0]         anodos,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        updated
);

  localparam int TICKS = ticks_per_digit(CLK_FREQ_HZ, REFRESH_HZ, N_DIGITS);
  localparam int IW    = $clog2(N_DIGITS);
  localparam int DW    = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
  localparam int VW    = DIGIT_W * N_DIGITS;

  if (TICKS < 4) begin : g_bad_ticks
    $error("module_display_scan: fewer than 4 clocks per digit");
  end
  if (DEAD_CYCLES >= TICKS) begin : g_bad_dead
    $error("module_display_scan: DEAD_CYCLES must be smaller than clocks per digit");
  end

  logic                tick;
  logic [IW-1:0]       idx, idx_next;
  logic [DW-1:0]       dead, dead_next;
  logic [VW-1:0]       disp_reg, disp_next, pend_reg;
  logic                pend_flag;
  logic                do_commit;
  logic [N_DIGITS-1:0] blank;
  logic [N_DIGITS-1:0] anodos_next;
  nibble_t             data_next;

  module_prescaler #(
    .TICKS(TICKS)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Commit only on the tick that wraps the last digit back to digit 0.
  assign do_commit = tick && (idx == IW'(N_DIGITS - 1)) && pend_flag;
  assign disp_next = do_commit ? pend_reg : disp_reg;

`ifdef LEADING_ZERO_BLANK_EN
  logic lz_seen;

  // Leading-zero detect on the value being shown after this edge.
  always_comb begin
    blank   = '0;
    lz_seen = 1'b0;
    for (int k = N_DIGITS - 1; k > 0; k--) begin
      lz_seen  = lz_seen | (disp_next[k*DIGIT_W +: DIGIT_W] != '0);
      blank[k] = ~lz_seen;
    end
  end
`else
  assign blank = '0;
`endif

  // Next scan position, dead-time counter and the outputs derived from them.
  always_comb begin
    idx_next    = idx;
    dead_next   = dead;
    anodos_next = {N_DIGITS{ANODOS_OFF}};
    if (tick) begin
      idx_next  = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      dead_next = DW'(DEAD_CYCLES);
    end else if (dead != '0) begin
      dead_next = dead - 1'b1;
    end
    data_next = disp_next[idx_next*DIGIT_W +: DIGIT_W];
    if (dead_next == '0 && !blank[idx_next]) begin
      anodos_next[idx_next] = ~ANODOS_OFF;
    end
  end

  // State, buffers and registered outputs all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      dead      <= '0;
      disp_reg  <= '0;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
      data      <= '0;
      anodos    <= {N_DIGITS{ANODOS_OFF}};
      digit_idx <= '0;
      updated   <= 1'b0;
    end else begin
      idx       <= idx_next;
      dead      <= dead_next;
      disp_reg  <= disp_next;
      data      <= data_next;
      anodos    <= anodos_next;
      digit_idx <= idx_next;
      updated   <= do_commit;
      if (load) begin
        pend_reg  <= value;
        pend_flag <= 1'b1;
      end else if (do_commit) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_module_display_scan.sv
// Self-checking bench for module_display_scan with TICKS=5, DEAD_CYCLES=1,
// 4 digits (20 clocks per frame).
module tb_module_display_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  data;
  logic [3:0]  anodos;
  logic [1:0]  digit_idx;
  logic        updated;

  int checks   = 0;
  int failures = 0;

  module_display_scan #(
    .N_DIGITS   (4),
    .CLK_FREQ_HZ(1000),
    .REFRESH_HZ (50),
    .DEAD_CYCLES(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .data     (data),
    .anodos   (anodos),
    .digit_idx(digit_idx),
    .updated  (updated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Digits above the highest nonzero nibble are dark when blanking is built in.
  function automatic logic [3:0] lz_mask(input logic [15:0] d);
    logic [3:0] m;
    m = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = 3; k > 0; k--) begin
      if (d[k*4 +: 4] != 4'h0) break;
      m[k] = 1'b1;
    end
`endif
    return m;
  endfunction

  typedef struct {
    logic [3:0] data;
    logic [3:0] anodos;
    logic [1:0] idx;
    logic       upd;
  } exp_t;

  exp_t sb[$];

  // Frame-position reference model: cyc counts edges since reset release.
  int          cyc;
  logic [15:0] m_disp, m_pend;
  logic        m_flag;

  always @(posedge clk) begin
    exp_t e;
    logic u;
    if (!rst_n) begin
      cyc = 0; m_disp = '0; m_pend = '0; m_flag = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      u = (cyc % 20 == 0) && m_flag;
      if (u) m_disp = m_pend;
      if (load) begin
        m_pend = value;
        m_flag = 1'b1;
      end else if (u) begin
        m_flag = 1'b0;
      end
      e.idx    = 2'((cyc / 5) % 4);
      e.data   = m_disp[e.idx*4 +: 4];
      e.anodos = (cyc % 5 == 0) ? 4'hF : (~(4'b0001 << e.idx) | lz_mask(m_disp));
      e.upd    = u;
      sb.push_back(e);
    end
  end

  // Scoreboard compare, one line per transaction only on mismatch.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_anodos", 16'(anodos), 16'hF);
      chk("rst_data", 16'(data), 16'h0);
      chk("rst_updated", 16'(updated), 16'h0);
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_data", 16'(data), 16'(e.data));
      chk("sb_anodos", 16'(anodos), 16'(e.anodos));
      chk("sb_idx", 16'(digit_idx), 16'(e.idx));
      chk("sb_updated", 16'(updated), 16'(e.upd));
    end
  end

  int upd_cnt = 0;
  always @(negedge clk) if (rst_n && updated) upd_cnt++;

  task automatic wait_mod(input int target);
    for (int i = 0; i < 100; i++) begin
      if (cyc % 20 == target) return;
      @(negedge clk);
    end
    chk("wait_timeout", 16'(cyc % 20), 16'(target));
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  typedef struct {
    logic [15:0] value;
    logic [15:0] shown;
    logic [3:0]  lz_blank;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int u0;
    logic [3:0] exp_an;
    vecs[0] = '{16'h1A3F, 16'h1A3F, 4'b0000};
    vecs[1] = '{16'h0042, 16'h0042, 4'b1100};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 4'b0000};
    vecs[3] = '{16'h0000, 16'h0000, 4'b1110};
    vecs[4] = '{16'h8001, 16'h8001, 4'b0000};

    rst_n = 1'b0; load = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_tick_idx", 16'(digit_idx), 16'h0);
    chk("pre_tick_anodos", 16'(anodos), 16'hE);
    @(negedge clk);
    chk("first_tick_idx", 16'(digit_idx), 16'h1);
    chk("first_tick_dead", 16'(anodos), 16'hF);

    // Table: load, wait for the wrap, then sample each slot mid-way.
    for (int v = 0; v < 5; v++) begin
      wait_mod(1);
      u0 = upd_cnt;
      do_load(vecs[v].value);
      wait_mod(0);
      for (int k = 0; k < 4; k++) begin
        wait_mod(k * 5 + 2);
        exp_an = ~(4'b0001 << k);
`ifdef LEADING_ZERO_BLANK_EN
        exp_an = exp_an | vecs[v].lz_blank;
`endif
        chk($sformatf("vec%0d_data%0d", v, k), 16'(data), 16'(vecs[v].shown[k*4 +: 4]));
        chk($sformatf("vec%0d_anodos%0d", v, k), 16'(anodos), 16'(exp_an));
      end
      chk($sformatf("vec%0d_upd_pulses", v), 16'(upd_cnt - u0), 16'd1);
    end

    // Last load before the wrap wins, single commit pulse.
    wait_mod(1);
    u0 = upd_cnt;
    do_load(16'h1111);
    do_load(16'h2222);
    wait_mod(0);
    for (int k = 0; k < 4; k++) begin
      wait_mod(k * 5 + 2);
      chk($sformatf("last_wins_data%0d", k), 16'(data), 16'h2);
    end
    chk("last_wins_pulses", 16'(upd_cnt - u0), 16'd1);

    // Load landing on the commit edge: old pending shown, new one next frame.
    wait_mod(1);
    u0 = upd_cnt;
    do_load(16'h1234);
    wait_mod(19);
    do_load(16'h5678);
    wait_mod(2);
    chk("simul_first_d0", 16'(data), 16'h4);
    wait_mod(17);
    chk("simul_first_d3", 16'(data), 16'h1);
    wait_mod(2);
    chk("simul_second_d0", 16'(data), 16'h8);
    wait_mod(17);
    chk("simul_second_d3", 16'(data), 16'h5);
    chk("simul_pulses", 16'(upd_cnt - u0), 16'd2);

    // Asynchronous reset mid-frame with a pending value.
    wait_mod(1);
    do_load(16'h9999);
    wait_mod(12);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_anodos", 16'(anodos), 16'hF);
    chk("midrst_data", 16'(data), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    u0 = upd_cnt;
    repeat (45) @(negedge clk);
    chk("midrst_no_commit", 16'(upd_cnt - u0), 16'd0);
    chk("midrst_data_zero", 16'(data), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
